// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : half_adder / serial_adder
// Purpose  : half_adder is the one-bit add cell. serial_adder adds two
//            WIDTH-bit operands plus a carry-in one bit per clock, LSB first,
//            using two half_adder cells and an OR as the full-add slice. It
//            holds the operand shift registers, the carry register and the
//            bit counter around that slice.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - request; sampled only while idle
//            a, b   - WIDTH-bit operands, captured on the accepting edge
//            cin    - carry-in, captured on the accepting edge
//            busy   - high while bits are being added
//            done   - one-cycle pulse once sout/cout carry the new result
//            sout   - registered sum of the last completed addition
//            cout   - registered carry-out of the last completed addition
// Revision : 1.0 - initial release
// ============================================================================

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout,
    output logic             cout
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_psum;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_s0;
    logic               w_c0;
    logic               w_s;
    logic               w_c1;
    logic               w_c_next;
    logic [WIDTH-1:0]   w_psum_next;

    // Full-add slice on the current LSBs and the carry register.
    half_adder u_ha0 (
        .a (r_sa[0]),
        .b (r_sb[0]),
        .s (w_s0),
        .c (w_c0)
    );

    half_adder u_ha1 (
        .a (w_s0),
        .b (r_c),
        .s (w_s),
        .c (w_c1)
    );

    assign w_c_next = w_c0 | w_c1;

    // New sum bit enters from the MSB side so that after WIDTH shifts bit 0
    // of the result has arrived at psum[0].
    assign w_psum_next = {w_s, {(WIDTH-1){1'b0}}} | (r_psum >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_psum  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sout    <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_c     <= cin;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ADD;
                    end
                end

                S_ADD: begin
                    r_sa   <= r_sa >> 1;
                    r_sb   <= r_sb >> 1;
                    r_psum <= w_psum_next;
                    r_c    <= w_c_next;
                    if (r_cnt == CNT_LAST) begin
                        // Last bit: publish the result on this edge only, so
                        // partial sums never reach sout.
                        r_cnt   <= '0;
                        sout    <= w_psum_next;
                        cout    <= w_c_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Scoreboard bench for serial_adder (WIDTH=8). Stimulus pushes the
//            expected {cout,sout} when it issues an addition; a monitor on the
//            falling edge pops and compares on every done pulse, checks the
//            busy length, result hold during busy and done spacing.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sout;
    logic             cout;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sout  (sout),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    logic [WIDTH:0] sb_q[$];
    logic [WIDTH:0] hold_res = '0;
    int             n_checks = 0;
    int             n_fail   = 0;
    int             busy_run = 0;
    int             cyc      = 0;
    int             last_done = -1;
    bit             held     = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        logic [WIDTH:0] exp;
        if (!rst_n) begin
            hold_res = '0;
            busy_run = 0;
        end else begin
            if (busy && done) flag("busy_and_done_together");
            if (busy) begin
                busy_run = busy_run + 1;
                chk("result_hold_while_busy", {23'd0, cout, sout}, {23'd0, hold_res});
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    flag("unexpected_done_pulse");
                end else begin
                    exp = sb_q.pop_front();
                    chk("result", {23'd0, cout, sout}, {23'd0, exp});
                    chk("busy_cycles", busy_run, WIDTH);
                    hold_res = exp;
                end
                if (held) begin
                    if (last_done >= 0) chk("done_period", cyc - last_done, WIDTH + 2);
                    last_done = cyc;
                end
                busy_run = 0;
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !done) ok = 1'b1;
        end
        if (!ok) flag("wait_idle_timeout");
    endtask

    task automatic do_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vc, input logic [WIDTH:0] expv);
        wait_idle();
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        sb_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [WIDTH:0] e;
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_sout", {24'd0, sout}, 0);
        chk("reset_cout", {31'd0, cout}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, expected {cout,sout} worked out by hand.
        do_op(8'h5A, 8'h3C, 1'b0, 9'h096);
        do_op(8'hFF, 8'h01, 1'b0, 9'h100);
        do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        do_op(8'h10, 8'h20, 1'b0, 9'h030);
        do_op(8'h01, 8'h01, 1'b0, 9'h002);

        // Operand change and start pulse in the middle of an addition.
        do_op(8'h12, 8'h34, 1'b1, 9'h047);
        repeat (3) @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;

        // Reset while bit 4 is in flight; the result is discarded.
        do_op(8'h33, 8'h44, 1'b0, 9'h077);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("midreset_busy", {31'd0, busy}, 0);
        chk("midreset_done", {31'd0, done}, 0);
        chk("midreset_sout", {24'd0, sout}, 0);
        chk("midreset_cout", {31'd0, cout}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("idle_after_reset_busy", {31'd0, busy}, 0);

        // start held high: one accept every WIDTH+2 edges, random operands.
        wait_idle();
        held      = 1'b1;
        last_done = -1;
        for (int i = 0; i < 1000; i++) begin
            a     = WIDTH'($urandom_range(0, 255));
            b     = WIDTH'($urandom_range(0, 255));
            cin   = 1'($urandom_range(0, 1));
            start = 1'b1;
            e     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            sb_q.push_back(e);
            @(posedge clk);
            repeat (WIDTH + 1) @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        held  = 1'b0;

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) flag("drain_timeout_missing_done");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
